// File: rtl/piso_tx_if.sv
// Load handshake and serial-output bundle between a word source and piso_tx.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    // Word source / bit-clock owner side.
    modport master (
        output din, load_valid, shift_en,
        input  load_ready, sout, sout_valid, busy, done
    );

    // Transmitter side.
    modport slave (
        input  din, load_valid, shift_en,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word over a
// valid/ready handshake and shifts it out LSB first, one bit per enabled
// clock. A new word can be taken in the last-bit cycle so words stream with
// no gap bit.
module piso_tx #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    piso_tx_if.slave bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_last;
    logic             w_load_ready;
    logic             w_done;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // State, shift register and bit counter; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic plus the two handshake-dependent outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_cnt_nxt    = r_cnt;
        w_load_ready = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_load_ready = 1'b1;
                if (bus.load_valid) begin
                    w_shreg_nxt = bus.din;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A stall holds everything, including a pending last bit,
                // so done and the reload opportunity wait for shift_en.
                if (bus.shift_en) begin
                    if (!w_last) begin
                        w_shreg_nxt = r_shreg >> 1;
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end else begin
                        w_done       = 1'b1;
                        w_load_ready = 1'b1;
                        if (bus.load_valid) begin
                            w_shreg_nxt = bus.din;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_shreg_nxt = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.load_ready = w_load_ready;
    assign bus.done       = w_done;
    assign bus.sout       = (r_state == SHIFT) ? r_shreg[0] : 1'b0;
    assign bus.sout_valid = (r_state == SHIFT);
    assign bus.busy       = (r_state == SHIFT);

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: expected bits are queued when a word is loaded
// and compared as the transmitter presents them; a 4-bit SIPO receiver on the
// serial side checks loopback word reassembly.
module tb_piso_tx;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;

    piso_tx_if #(.WIDTH(WIDTH)) bus ();

    piso_tx #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver: shifts in at its MSB whenever a live bit is consumed.
    logic [WIDTH-1:0] sipo_q;
    always @(posedge clk) begin
        if (bus.sout_valid && bus.shift_en)
            sipo_q <= {bus.sout, sipo_q[WIDTH-1:1]};
    end

    int   n_checks = 0;
    int   n_err    = 0;
    logic sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [WIDTH-1:0] d, input logic se);
        bus.load_valid = lv;
        bus.din        = d;
        bus.shift_en   = se;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) sb_q.push_back(w[i]);
    endtask

    // One clock cycle: check this cycle's outputs, then advance past the edge.
    task automatic tick(input logic e_ready, input logic e_done, input logic e_busy);
        logic exp_bit;
        #1;
        check("load_ready", bus.load_ready, e_ready);
        check("done", bus.done, e_done);
        check("busy", bus.busy, e_busy);
        check("sout_valid", bus.sout_valid, e_busy);
        if (e_busy) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                exp_bit = sb_q[0];
                check("sout", bus.sout, exp_bit);
                if (bus.shift_en) void'(sb_q.pop_front());
            end
        end else begin
            check("sout_idle", bus.sout, 1'b0);
        end
        @(posedge clk);
        #1;
        if (!rst_n) sb_q.delete();
    endtask

    initial begin
        // Reset held with a pending load: nothing may be taken.
        rst_n = 1'b0;
        drive(1'b1, 4'hF, 1'b1);
        @(posedge clk);
        #1;
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);

        // Single word 1011 -> 1,1,0,1.
        drive(1'b1, 4'b1011, 1'b1);
        push_word(4'b1011);
        tick(1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("sb_empty_single", sb_q.size(), 0);

        // Back-to-back A then 5 with load_valid held.
        drive(1'b1, 4'hA, 1'b1);
        push_word(4'hA);
        tick(1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'h5, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        push_word(4'h5);
        tick(1'b1, 1'b1, 1'b1);
        drive(1'b0, 4'h0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("sb_empty_b2b", sb_q.size(), 0);

        // Stall two cycles after bit 1 of 0110.
        drive(1'b1, 4'b0110, 1'b1);
        push_word(4'b0110);
        tick(1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);

        // Stall in the last-bit cycle defers done and the reload.
        drive(1'b1, 4'h2, 1'b1);
        push_word(4'h2);
        tick(1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'h9, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'h9, 1'b1);
        push_word(4'h9);
        tick(1'b1, 1'b1, 1'b1);
        drive(1'b0, 4'h0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("sb_empty_stall", sb_q.size(), 0);

        // Load attempt while busy is ignored: 3 still sends 1,1,0,0.
        drive(1'b1, 4'h3, 1'b1);
        push_word(4'h3);
        tick(1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'hC, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);

        // Reset after bit 2 of E: word dropped, no done.
        drive(1'b1, 4'hE, 1'b1);
        push_word(4'hE);
        tick(1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1);
        repeat (2) tick(1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        check("sb_flushed", sb_q.size(), 0);
        drive(1'b1, 4'h9, 1'b1);
        push_word(4'h9);
        tick(1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("sb_empty_reset", sb_q.size(), 0);

        // Loopback stream of 0..F into the SIPO, back-to-back.
        drive(1'b1, 4'h0, 1'b1);
        push_word(4'h0);
        tick(1'b1, 1'b0, 1'b0);
        for (int w = 0; w < 16; w++) begin
            drive(1'b0, 4'h0, 1'b1);
            repeat (3) tick(1'b0, 1'b0, 1'b1);
            if (w < 15) begin
                drive(1'b1, 4'(w + 1), 1'b1);
                push_word(4'(w + 1));
            end else begin
                drive(1'b0, 4'h0, 1'b1);
            end
            tick(1'b1, 1'b1, 1'b1);
            check("sipo_q", sipo_q, 32'(w));
        end
        drive(1'b0, 4'h0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("sb_empty_loop", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter. It is the sending end of the team's 4-bit serial-in parallel-out shift-register link.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock, LSB first.
- Because it sends LSB first, a SIPO that shifts in at its MSB and is clocked on the same edges holds the original word, in original bit order, after WIDTH shifts.
- Sits upstream of the SIPO receiver in loopback and serial-link test designs.

Parameters:
- WIDTH, 4, word length in bits; legal range ≥2.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous reset, active-low.
- din  input  WIDTH  parallel word to transmit.
- load_valid  input  1  din is valid and requests transmission.
- load_ready  output  1  the block accepts din this cycle.
- shift_en  input  1  advance one bit this cycle. When 0 in SHIFT, the block stalls.
- sout  output  1  serial data out.
- sout_valid  output  1  sout carries a live data bit.
- busy  output  1  a word is in flight.
- done  output  1  single-cycle pulse: the last bit of a word is being shifted this cycle.

Behaviour:
- Registers: shreg[WIDTH-1:0], cnt[CW-1:0], state ∈ {IDLE, SHIFT}.
- Reset: rst_n sampled low at a rising edge sets state=IDLE, shreg=0, cnt=0.
  - After that edge: load_ready=1, sout=0, sout_valid=0, busy=0, done=0.
  - Reset mid-word discards the word; no done pulse is issued for it.
- Outputs:
  - sout = shreg[0] when state==SHIFT, else 0.
  - sout_valid = busy = (state==SHIFT).
  - All outputs derive only from registers, plus shift_en/load_valid for load_ready and done as defined below.
- Handshake: a load is accepted at an edge where load_valid & load_ready = 1. load_valid while load_ready=0 is ignored; there is no queueing. din is sampled only at the accept edge.
- IDLE:
  - load_ready=1.
  - On accept: shreg←din, cnt←0, state←SHIFT.
  - Latency: bit din[0] appears on sout in the cycle after the accept edge.
- SHIFT, shift_en=0 (stall):
  - shreg, cnt, and state hold; sout holds its bit.
  - load_ready=0, done=0.
- SHIFT, shift_en=1, cnt<WIDTH-1:
  - shreg←shreg>>1 (MSB filled with 0), cnt←cnt+1.
  - load_ready=0, done=0.
- SHIFT, shift_en=1, cnt==WIDTH-1 (last bit):
  - done=1 and load_ready=1 this cycle.
  - If load_valid=1: shreg←din, cnt←0, state stays SHIFT. Back-to-back words have no gap bit; sout_valid stays high.
  - Else: state←IDLE, shreg←0, cnt←0.
- Per word: WIDTH enabled cycles. Minimum word period is WIDTH cycles when shift_en is held 1 and loads are back-to-back.
- Simultaneous events:
  - rst_n low overrides load and shift.
  - A stall in the last-bit cycle defers both done and load acceptance until the cycle in which shift_en=1.
- cnt never exceeds WIDTH-1. There is no wrap-around other than the reload to 0.
- Receiver pairing: a SIPO whose d=sout is clocked on the same edges, gated by (sout_valid & shift_en). After the done edge it holds q==word.

Test Plan:
- Reset sanity: hold rst_n=0 for 3 cycles with load_valid=1 and din=4'hF -> load_ready=1, sout=0, sout_valid=0, busy=0, done=0 throughout; no load is taken.
- Single word: din=4'b1011 with shift_en=1 -> sout = 1,1,0,1 over cycles 1–4 after accept. done is high only in cycle 4. Cycle 5: IDLE, sout_valid=0.
- Back-to-back: 4'hA, then 4'h5 presented with load_valid held → 4'h5 accepted in the last-bit cycle of 4'hA.
  - Continuous stream 0,1,0,1,1,0,1,0.
  - sout_valid high for 8 cycles; done in cycles 4 and 8.
- Stall: din=4'b0110, shift_en=0 for 2 cycles after bit 1 -> sout holds 1 for 3 cycles. Total 6 cycles to done. Bit order is unchanged.
- Busy-ignore and reset mid-word:
  - Pulse load_valid with din=4'hC during bit 2 of 4'h3 -> ignored; output is still 1,1,0,0.
  - Then drive rst_n=0 after bit 2 of a new word -> next cycle IDLE, no done pulse. The next load of 4'h9 transmits 1,0,0,1 cleanly.
- Loopback: WIDTH=4 driving a 4-bit SIPO gated per the pairing rule; send words 0x0 to 0xF -> the SIPO q equals each word on the cycle after its done pulse.
